inst_encoder_loader: RTL

//  Reverse of the instruction decoder: packs decoded fields (opcode, rd, rs1, rs2, imm, funct3, funct7)

---
 rtl/inst_encoder_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32 fields (I-load, S, R, B) into instruction words
// and streams them sequentially into instruction memory, one write per beat.
// Ports: clk, rst_n, start/base_addr (session), in_valid/in_ready/in_last +
// opcode/rd/rs1/rs2/imm/funct3/funct7 (beats), mem_we/mem_addr/mem_wdata
// (write port), word_count/done/full/err (status).
module inst_encoder_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [11:0]           imm,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [15:0]           word_count,
  output logic                  done,
  output logic                  full,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [31:0]           enc;
  logic                  legal;
  logic                  accept;
  logic [15:0]           cnt_nx;
  logic                  hit_max;

  logic is_i, is_s, is_r, is_b;

  assign is_i = (opcode == 7'b0000011);
  assign is_s = (opcode == 7'b0100011);
  assign is_r = (opcode == 7'b0110011);
  assign is_b = (opcode == 7'b1100011);

  // B imm holds offset>>1, so imm[11] is offset bit 12
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    unique case (1'b1)
      is_i: enc = {imm, rs1, funct3, rd, opcode};
      is_s: enc = {imm[11:5], rs2, rs1, funct3,
                   imm[4:0], opcode};
      is_r: enc = {funct7, rs2, rs1, funct3,
                   rd, opcode};
      is_b: enc = {imm[11], imm[9:4], rs2, rs1,
                   funct3, imm[3:0], imm[10],
                   opcode};
      default: legal = 1'b0;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign cnt_nx  = word_count + 16'd1;
  assign hit_max = legal && (cnt_nx == MAXW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            ptr        <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (legal) begin
              mem_we    <= 1'b1;
              mem_wdata <= enc;
              mem_addr  <= ptr;
              ptr       <= ptr + ADDR_WIDTH'(4);
              if (word_count != MAXW) begin
                word_count <= cnt_nx;
              end
              full <= (cnt_nx >= MAXW);
            end else begin
              err <= 1'b1;
            end
            if (in_last || hit_max) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        // the final write is on the port during this state
        FLUSH: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
